// File: rtl/defender_ctrl_mapper.sv
// Defender control input conditioning: debounces joystick/coin, synchronises the ship
// facing bit and maps controls to registered thrust/reverse/coin strobes per mode.
module defender_ctrl_mapper #(
  parameter int DEB_CYC       = 24000,
  parameter int REV_PULSE_CYC = 400000,
  parameter int FLIP_TIMEOUT  = 2400000,
  parameter int COIN_MIN_CYC  = 2400000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic       joy_left,
  input  logic       joy_right,
  input  logic       fire_b,
  input  logic       fire_e,
  input  logic       coin_in,
  input  logic       facing,
  output logic       thrust,
  output logic       reverse,
  output logic       coin_out
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int RW = $clog2(REV_PULSE_CYC + 1);
  localparam int FW = $clog2(FLIP_TIMEOUT + 1);
  localparam int CW = $clog2(COIN_MIN_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REV       = 2'd1,
    S_WAIT_FLIP = 2'd2,
    S_WAIT_REL  = 2'd3
  } state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_deb;
  logic [DW-1:0] r_deb_cnt [3];
  logic          w_dl;
  logic          w_dr;
  logic          w_dc;

  logic          r_fac_meta;
  logic          r_fac_s;
  logic          r_fac_lat;
  logic [1:0]    r_mode_q;
  logic          r_bwd_q;
  logic          r_dc_q;

  logic          w_fwd;
  logic          w_bwd;
  logic          w_mode2;
  logic          w_mode_chg;
  logic          w_bwd_rise;
  logic          w_flip;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_rev_cnt;
  logic [FW-1:0] r_flip_cnt;

  logic          w_thrust_nxt;
  logic          w_rev_nxt;

  logic          r_coin_armed;
  logic [CW-1:0] r_coin_cnt;

  assign w_raw = {coin_in, joy_right, joy_left};
  assign w_dl  = r_deb[0];
  assign w_dr  = r_deb[1];
  assign w_dc  = r_deb[2];

  // Per-input debounce: a level is accepted after DEB_CYC consecutive differing samples
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= 3'b000;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_raw[i] == r_deb[i]) begin
          r_deb_cnt[i] <= {DW{1'b0}};
        end else if (r_deb_cnt[i] >= DW'(DEB_CYC - 1)) begin
          r_deb[i]     <= w_raw[i];
          r_deb_cnt[i] <= {DW{1'b0}};
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Facing synchroniser plus one-cycle history used for edge and mode-change detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_fac_meta <= 1'b0;
      r_fac_s    <= 1'b0;
      r_mode_q   <= 2'b00;
      r_bwd_q    <= 1'b0;
      r_dc_q     <= 1'b0;
    end else begin
      r_fac_meta <= facing;
      r_fac_s    <= r_fac_meta;
      r_mode_q   <= mode;
      r_bwd_q    <= w_bwd;
      r_dc_q     <= w_dc;
    end
  end

  // Pushing both ways at once cancels both facing-relative terms
  assign w_fwd      = (w_dl & w_dr) ? 1'b0 : (r_fac_s ? w_dr : w_dl);
  assign w_bwd      = (w_dl & w_dr) ? 1'b0 : (r_fac_s ? w_dl : w_dr);
  assign w_mode2    = (mode == 2'b01);
  assign w_mode_chg = (mode != r_mode_q);
  assign w_bwd_rise = w_bwd & ~r_bwd_q;
  assign w_flip     = (r_fac_s != r_fac_lat);

  // Mode 2 FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Mode 2 FSM next-state logic; a mode change always wins
  always_comb begin
    w_state_nxt = r_state;
    if (!w_mode2 || w_mode_chg) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_bwd_rise) w_state_nxt = S_REV;
          else            w_state_nxt = S_IDLE;
        end
        S_REV: begin
          if (r_rev_cnt >= RW'(REV_PULSE_CYC - 1)) w_state_nxt = S_WAIT_FLIP;
          else                                     w_state_nxt = S_REV;
        end
        S_WAIT_FLIP: begin
          if (w_flip)                                  w_state_nxt = S_IDLE;
          else if (r_flip_cnt >= FW'(FLIP_TIMEOUT - 1)) w_state_nxt = S_WAIT_REL;
          else if (!w_fwd && !w_bwd)                   w_state_nxt = S_IDLE;
          else                                         w_state_nxt = S_WAIT_FLIP;
        end
        S_WAIT_REL: begin
          if (!w_dl && !w_dr) w_state_nxt = S_IDLE;
          else                w_state_nxt = S_WAIT_REL;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Reverse-pulse and flip-wait counters, cleared whenever their state is left
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rev_cnt  <= {RW{1'b0}};
      r_flip_cnt <= {FW{1'b0}};
      r_fac_lat  <= 1'b0;
    end else begin
      if (r_state == S_REV && w_state_nxt == S_REV) r_rev_cnt <= r_rev_cnt + RW'(1);
      else                                          r_rev_cnt <= {RW{1'b0}};
      if (r_state == S_WAIT_FLIP && w_state_nxt == S_WAIT_FLIP) r_flip_cnt <= r_flip_cnt + FW'(1);
      else                                                      r_flip_cnt <= {FW{1'b0}};
      if (r_state == S_IDLE && w_state_nxt == S_REV) r_fac_lat <= r_fac_s;
      else                                           r_fac_lat <= r_fac_lat;
    end
  end

  // Output mapping; a flip seen in WAIT_FLIP releases thrust in the same cycle it is detected
  always_comb begin
    w_thrust_nxt = 1'b0;
    w_rev_nxt    = 1'b0;
    case (mode)
      2'b00, 2'b11: begin
        w_thrust_nxt = w_dl | w_dr;
        w_rev_nxt    = fire_b;
      end
      2'b10: begin
        w_thrust_nxt = fire_e;
        w_rev_nxt    = fire_b;
      end
      2'b01: begin
        if (w_mode_chg) begin
          w_thrust_nxt = w_fwd;
        end else begin
          case (r_state)
            S_IDLE:      w_thrust_nxt = w_fwd;
            S_REV:       w_rev_nxt    = 1'b1;
            S_WAIT_FLIP: w_thrust_nxt = w_flip ? w_fwd : 1'b0;
            S_WAIT_REL:  w_thrust_nxt = 1'b0;
            default:     w_thrust_nxt = 1'b0;
          endcase
        end
      end
      default: begin
        w_thrust_nxt = 1'b0;
        w_rev_nxt    = 1'b0;
      end
    endcase
  end

  // Registered thrust/reverse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      thrust  <= 1'b0;
      reverse <= 1'b0;
    end else begin
      thrust  <= w_thrust_nxt;
      reverse <= w_rev_nxt;
    end
  end

  // Coin stretcher: one COIN_MIN_CYC pulse per accepted edge, re-armed once coin is low again
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_out     <= 1'b0;
      r_coin_armed <= 1'b1;
      r_coin_cnt   <= {CW{1'b0}};
    end else if (coin_out) begin
      if (r_coin_cnt >= CW'(COIN_MIN_CYC - 1)) begin
        coin_out   <= 1'b0;
        r_coin_cnt <= {CW{1'b0}};
      end else begin
        r_coin_cnt <= r_coin_cnt + CW'(1);
      end
    end else if (r_coin_armed) begin
      if (w_dc && !r_dc_q) begin
        coin_out     <= 1'b1;
        r_coin_armed <= 1'b0;
      end
      r_coin_cnt <= {CW{1'b0}};
    end else begin
      r_coin_armed <= ~w_dc;
      r_coin_cnt   <= {CW{1'b0}};
    end
  end

endmodule

// File: tb/tb_defender_ctrl_mapper.sv
// Directed bench for defender_ctrl_mapper: table of undebounced mapping vectors plus
// hand-timed sequences for debounce, Mode 2 reverse/flip/timeout, coin and interrupts.
module tb_defender_ctrl_mapper;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       joy_left, joy_right, fire_b, fire_e, coin_in, facing;
  logic       thrust, reverse, coin_out;

  int n_checks = 0;
  int n_errors = 0;

  defender_ctrl_mapper #(
    .DEB_CYC(4), .REV_PULSE_CYC(8), .FLIP_TIMEOUT(32), .COIN_MIN_CYC(16)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .mode(mode),
    .joy_left(joy_left), .joy_right(joy_right), .fire_b(fire_b), .fire_e(fire_e),
    .coin_in(coin_in), .facing(facing),
    .thrust(thrust), .reverse(reverse), .coin_out(coin_out)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic       fb;
    logic       fe;
    logic       exp_t;
    logic       exp_r;
  } vec_t;

  vec_t vecs [7];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int n_rev, n_thr, n_coin;

    vecs[0] = '{"m1_fireb",   2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"m1_firee",   2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"cab_firee",  2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"cab_both",   2'b10, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{"m11_as_m1",  2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"m2_buttons", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"cab_idle",   2'b10, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; mode = 2'b00; joy_left = 1'b0; joy_right = 1'b0;
    fire_b = 1'b0; fire_e = 1'b0; coin_in = 1'b0; facing = 1'b0;
    #3;
    check("rst_thrust", thrust, 1'b0);
    check("rst_reverse", reverse, 1'b0);
    check("rst_coin", coin_out, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Undebounced button paths: one cycle latency
    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].mode; fire_b = vecs[i].fb; fire_e = vecs[i].fe;
      tick(1);
      check({vecs[i].name, "_thrust"}, thrust, vecs[i].exp_t);
      check({vecs[i].name, "_reverse"}, reverse, vecs[i].exp_r);
    end
    fire_b = 1'b0; fire_e = 1'b0; mode = 2'b00;
    tick(2);

    // Scenario 1: glitches rejected, stable high seen 5 cycles later
    for (int g = 0; g < 3; g++) begin
      joy_left = 1'b1; tick(1); check("s1_glitch_hi", thrust, 1'b0);
      joy_left = 1'b0; tick(1); check("s1_glitch_lo", thrust, 1'b0);
    end
    joy_left = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("s1_debounce", thrust, k == 5);
    end
    joy_left = 1'b0;
    tick(6);
    check("s1_release", thrust, 1'b0);

    // Scenario 2: Mode 2 reverse pulse then facing flip
    mode = 2'b01;
    tick(3);
    joy_right = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      check("s2_reverse", reverse, (k >= 6 && k <= 13));
      check("s2_thrust_off", thrust, 1'b0);
    end
    tick(2);
    facing = 1'b1;
    tick(1); check("s2_flip_lat1", thrust, 1'b0);
    tick(1); check("s2_flip_lat2", thrust, 1'b0);
    tick(1); check("s2_flip_thrust", thrust, 1'b1);
    check("s2_flip_rev", reverse, 1'b0);
    joy_right = 1'b0;
    tick(6);
    check("s2_release", thrust, 1'b0);
    facing = 1'b0;
    tick(4);

    // Scenario 3: no flip, timeout, hold until release
    joy_right = 1'b1; n_rev = 0; n_thr = 0;
    for (int k = 1; k <= 54; k++) begin
      tick(1);
      if (reverse) n_rev++;
      if (thrust)  n_thr++;
    end
    check_int("s3_rev_len", n_rev, 8);
    check_int("s3_thrust_cnt", n_thr, 0);
    facing = 1'b1;
    tick(4);
    check("s3_waitrel_thrust", thrust, 1'b0);
    check("s3_waitrel_rev", reverse, 1'b0);
    joy_right = 1'b0;
    tick(6);
    joy_right = 1'b1;
    tick(4); check("s3_idle_pre", thrust, 1'b0);
    tick(1); check("s3_idle_thrust", thrust, 1'b1);
    check("s3_idle_rev", reverse, 1'b0);
    joy_right = 1'b0;
    facing = 1'b0;
    tick(8);

    // Scenario 5a: mode change during REV drops reverse next cycle, no re-pulse
    joy_right = 1'b1;
    tick(8);
    check("s5_rev_on", reverse, 1'b1);
    mode = 2'b00;
    tick(1);
    check("s5_rev_drop", reverse, 1'b0);
    check("s5_m1_thrust", thrust, 1'b1);
    mode = 2'b01; n_rev = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (reverse) n_rev++;
    end
    check_int("s5_no_repulse", n_rev, 0);
    joy_right = 1'b0;
    tick(6);

    // bwd rising edge coincident with a mode change: mode change wins
    mode = 2'b00;
    tick(2);
    joy_right = 1'b1;
    tick(4);
    mode = 2'b01; n_rev = 0;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      if (reverse) n_rev++;
    end
    check_int("s5_simul_no_pulse", n_rev, 0);
    joy_right = 1'b0;
    tick(6);

    // Scenario 6: Mode 2 conflict
    joy_left = 1'b1; joy_right = 1'b1; n_rev = 0; n_thr = 0;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      if (reverse) n_rev++;
      if (thrust)  n_thr++;
    end
    check_int("s6_conflict_rev", n_rev, 0);
    check_int("s6_conflict_thrust", n_thr, 0);
    joy_left = 1'b0; joy_right = 1'b0;
    tick(6);

    // Scenario 4: coin stretch, second press ignored, then a fresh pulse
    coin_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      check("s4_pulse1", coin_out, (k >= 5 && k <= 20));
      if (k == 6)  coin_in = 1'b0;
      if (k == 11) coin_in = 1'b1;
      if (k == 17) coin_in = 1'b0;
    end
    coin_in = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      check("s4_pulse2", coin_out, (k >= 5 && k <= 20));
      if (k == 6) coin_in = 1'b0;
    end

    // Scenario 5b: asynchronous reset mid coin pulse
    coin_in = 1'b1;
    tick(8);
    check("s5_coin_on", coin_out, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("s5_async_coin", coin_out, 1'b0);
    check("s5_async_thrust", thrust, 1'b0);
    coin_in = 1'b0;
    tick(2);
    reset_n = 1'b1; n_coin = 0; n_thr = 0; n_rev = 0;
    for (int k = 0; k < 24; k++) begin
      tick(1);
      if (coin_out) n_coin++;
      if (thrust)   n_thr++;
      if (reverse)  n_rev++;
    end
    check_int("s5_post_rst_coin", n_coin, 0);
    check_int("s5_post_rst_thrust", n_thr, 0);
    check_int("s5_post_rst_rev", n_rev, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
